// File: rtl/router_fifo_pkt.sv
`default_nettype none
// ============================================================================
// router_fifo_pkt
//   Router output FIFO storing bytes plus a header marker, with read-side
//   packet SOP/EOP tracking, occupancy flags and sticky overflow/underflow.
//   Revision: 1.0
// ============================================================================
module router_fifo_pkt #(
    parameter int DATA_W       = 8,
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = $clog2(DEPTH),
    parameter int LEN_LSB      = 2,
    parameter int LEN_W        = 6,
    parameter int AFULL_THRESH = 14
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              soft_reset,
    input  logic              write_enb,
    input  logic              read_enb,
    input  logic              lfd_state,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              sop_out,
    output logic              eop_out,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W:0] c_DEPTH = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] c_AFULL = AFULL_THRESH[ADDR_W:0];

    logic [DATA_W:0]   r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic [LEN_W:0]    r_pkt_cnt;
    logic [DATA_W-1:0] r_data_out;
    logic              r_sop;
    logic              r_eop;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_empty;
    logic              w_full;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [DATA_W:0]   w_rd_word;
    logic [LEN_W:0]    w_hdr_len;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_DEPTH);
    assign w_wr_acc  = write_enb && !w_full;
    assign w_rd_acc  = read_enb && !w_empty;
    assign w_rd_word = r_mem[r_rd_ptr];
    // Header length counts payload bytes; +1 covers the trailing parity byte.
    assign w_hdr_len = {1'b0, w_rd_word[LEN_LSB +: LEN_W]} + (LEN_W+1)'(1);

    always_ff @(posedge clock) begin
        if (!soft_reset && w_wr_acc) begin
            r_mem[r_wr_ptr] <= {lfd_state, data_in};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_pkt_cnt   <= '0;
            r_data_out  <= '0;
            r_sop       <= 1'b0;
            r_eop       <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (soft_reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_pkt_cnt   <= '0;
            r_data_out  <= '0;
            r_sop       <= 1'b0;
            r_eop       <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (write_enb && w_full) begin
                r_overflow <= 1'b1;
            end
            if (read_enb && w_empty) begin
                r_underflow <= 1'b1;
            end
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
                2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_rd_acc) begin
                r_rd_ptr   <= r_rd_ptr + ADDR_W'(1);
                r_data_out <= w_rd_word[DATA_W-1:0];
                if (w_rd_word[DATA_W]) begin
                    // A header always restarts tracking, even mid-packet.
                    r_pkt_cnt <= w_hdr_len;
                    r_sop     <= 1'b1;
                    r_eop     <= 1'b0;
                end else if (r_pkt_cnt != '0) begin
                    r_pkt_cnt <= r_pkt_cnt - (LEN_W+1)'(1);
                    r_sop     <= 1'b0;
                    r_eop     <= (r_pkt_cnt == (LEN_W+1)'(1));
                end else begin
                    r_sop <= 1'b0;
                    r_eop <= 1'b0;
                end
            end
        end
    end

    assign data_out    = r_data_out;
    assign sop_out     = r_sop;
    assign eop_out     = r_eop;
    assign empty       = w_empty;
    assign full        = w_full;
    assign almost_full = (r_count >= c_AFULL);
    assign count       = r_count;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;

endmodule
`default_nettype wire

// File: doc/router_fifo_pkt.md
Name: router_fifo_pkt

Overview:
- Parametrised successor to the router output FIFO.
- Stores DATA_W-bit bytes plus a per-entry header marker, captured from lfd_state.
- Tracks packet boundaries on the read side and flags start and end of each packet.
- Reports occupancy, almost-full, and sticky overflow/underflow errors.
- Sits between the router synchroniser/FSM write side and one output port's read side.

Parameters:
- DATA_W, 8: byte width of data_in/data_out.
- DEPTH, 16: number of entries; must be a power of 2, at least 4.
- ADDR_W, $clog2(DEPTH): pointer width (derived; not overridden).
- LEN_LSB, 2: LSB position of the payload-length field in a header byte.
- LEN_W, 6: width of the payload-length field.
- AFULL_THRESH, 14: occupancy at which almost_full asserts; 1 to DEPTH.

Ports:
- clock, in, 1: sole clock; all logic on rising edge.
- reset, in, 1: asynchronous, active-high reset.
- soft_reset, in, 1: synchronous flush, active-high.
- write_enb, in, 1: write request.
- read_enb, in, 1: read request.
- lfd_state, in, 1: marks data_in as a header byte (stored with the entry).
- data_in, in, DATA_W: write data.
- data_out, out, DATA_W: registered read data.
- sop_out, out, 1: data_out is a header byte.
- eop_out, out, 1: data_out is the last byte (parity) of a packet.
- empty, out, 1: count==0.
- full, out, 1: count==DEPTH.
- almost_full, out, 1: count>=AFULL_THRESH.
- count, out, ADDR_W+1: current occupancy.
- overflow, out, 1: sticky; write attempted while full.
- underflow, out, 1: sticky; read attempted while empty.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: data_out=0, sop_out=0, eop_out=0, count=0, empty=1, full=0, almost_full=0, overflow=0, underflow=0; pointers=0, pkt_cnt=0.
- Storage: DEPTH x (DATA_W+1); the extra bit holds lfd_state.
- Flags: empty, full and almost_full are combinational decodes of the count register.
- Write: accepted when write_enb && !full. mem[wr_ptr] <= {lfd_state, data_in}; wr_ptr++.
- Write while full: write_enb && full → write dropped, overflow<=1.
- Read: accepted when read_enb && !empty.
  - data_out <= mem[rd_ptr].data on the same edge; 1-cycle latency from the read_enb sample.
  - rd_ptr++.
- Read while empty: read_enb && empty → data_out, sop_out, eop_out unchanged; underflow<=1.
- Simultaneous read+write: acceptance of each is judged on the pre-edge full/empty.
  - Both accepted → count unchanged.
  - Full → only the read is accepted; count-1; overflow set.
  - Empty → only the write is accepted; no bypass; underflow set.
- Pointers: wrap modulo DEPTH naturally; ordering is preserved across the wrap.
- Packet tracking (read side), register pkt_cnt of LEN_W+1 bits:
  - Accepted read of an entry with marker=1: pkt_cnt <= len+1, where len = data[LEN_LSB+:LEN_W] (payload + parity). sop_out<=1, eop_out<=0.
  - Accepted read of an entry with marker=0 and pkt_cnt>0: pkt_cnt--. eop_out<=1 iff pkt_cnt==1 before the decrement. sop_out<=0.
  - Header with len=0: the next read is parity and carries eop_out=1.
  - A marker=1 entry arriving while pkt_cnt>0 (truncated packet): treated as a new header; pkt_cnt is reloaded.
  - Read of a marker=0 entry with pkt_cnt==0 (stray byte): data is delivered, sop_out=eop_out=0.
  - sop_out/eop_out are registered with data_out. On cycles with no accepted read they hold their previous values alongside data_out.
- soft_reset (synchronous, highest priority after reset):
  - Clears pointers, count, pkt_cnt, data_out, sop_out, eop_out, overflow and underflow.
  - Any write_enb/read_enb in the same cycle is ignored.
  - Memory contents are not cleared.
- Reset mid-packet: asynchronous return to all reset values; the partial packet is discarded.
- No combinational path from inputs to data_out/sop_out/eop_out.

Test Plan:
- Reset/idle: assert reset for 2 cycles, then release → empty=1, full=0, count=0, data_out=0x00, overflow=underflow=0.
- Fill to full: write header 0x39 (len 14, addr 01, lfd=1), then 14 payload bytes, then parity 0xA5 → almost_full=1 at count=14, full=1 at count=16. A 17th write is dropped and overflow=1.
- Drain packet: read_enb held for 16 cycles.
  - First data_out=0x39 with sop_out=1, one cycle after the first read.
  - 16th data_out=0xA5 with eop_out=1.
  - empty=1 and count=0 afterwards.
  - A 17th read gives underflow=1 and data_out still 0xA5.
- Wrap + simultaneous: advance pointers to 12, fill to count=8, then read+write together for 10 cycles → count stays 8. Data read out matches written order across the 15→0 wrap.
- Short packet: header 0x01 (len 0), then parity 0x3C → 1st read sop_out=1 with data 0x01; 2nd read eop_out=1 with data 0x3C.
- soft_reset mid-packet: after 5 of 16 reads, pulse soft_reset with write_enb=1 → count=0, empty=1, data_out=0, sop_out=eop_out=0, no write occurred. A new header 0x0A then reads back with sop_out=1.
